// File: rtl/pipelined_tiny_alu.sv
// Pipelined 8-op ALU: one op per cycle, tagged, in-order completions.
// Latency: non-MUL 1 cycle, MUL MUL_LATENCY cycles (fully pipelined).
// Backpressure: in_ready drops for non-MUL ops only while a MUL is still in flight and not completing.
module pipelined_tiny_alu #(
    parameter int DATA_WIDTH  = 16,
    parameter int MUL_LATENCY = 3,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_op,
    input  logic [2:0]                op_sel,
    input  logic [DATA_WIDTH-1:0]     A1,
    input  logic [DATA_WIDTH-1:0]     B1,
    input  logic [TAG_WIDTH-1:0]      tag_in,
    output logic                      in_ready,
    output logic [2*DATA_WIDTH-1:0]   result,
    output logic [TAG_WIDTH-1:0]      tag_out,
    output logic                      end_op,
    output logic                      busy
);

    localparam int RESULT_WIDTH = 2 * DATA_WIDTH;
    localparam int NSTG         = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;

    localparam logic [2:0] OP_MUL     = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_SUB     = 3'b010;
    localparam logic [2:0] OP_ADDINCR = 3'b011;
    localparam logic [2:0] OP_OR      = 3'b100;
    localparam logic [2:0] OP_AND     = 3'b101;
    localparam logic [2:0] OP_XOR     = 3'b110;
    localparam logic [2:0] OP_NOT     = 3'b111;

    logic                    is_mul;
    logic                    accept;
    logic [RESULT_WIDTH-1:0] a_x;
    logic [RESULT_WIDTH-1:0] b_x;
    logic [RESULT_WIDTH-1:0] alu_res;

    logic [NSTG-1:0]         stg_vld_q, stg_vld_d;
    logic [RESULT_WIDTH-1:0] stg_prod_q [NSTG];
    logic [RESULT_WIDTH-1:0] stg_prod_d [NSTG];
    logic [TAG_WIDTH-1:0]    stg_tag_q  [NSTG];
    logic [TAG_WIDTH-1:0]    stg_tag_d  [NSTG];

    logic [RESULT_WIDTH-1:0] result_q, result_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic                    end_op_q, end_op_d;
    logic                    out_mul_q, out_mul_d;

    assign is_mul = (op_sel == OP_MUL);
    // Any valid MUL stage is a MUL that will not complete this cycle, so a non-MUL must wait.
    assign in_ready = !rst && (is_mul || !(|stg_vld_q));
    assign accept   = start_op && in_ready;

    always_comb begin
        a_x = {{DATA_WIDTH{1'b0}}, A1};
        b_x = {{DATA_WIDTH{1'b0}}, B1};
        alu_res = '0;
        case (op_sel)
            OP_MUL:     alu_res = a_x * b_x;
            OP_ADD:     alu_res = a_x + b_x;
            OP_SUB:     alu_res = a_x - b_x;
            OP_ADDINCR: alu_res = a_x + b_x + RESULT_WIDTH'(1);
            OP_OR:      alu_res = a_x | b_x;
            OP_AND:     alu_res = a_x & b_x;
            OP_XOR:     alu_res = a_x ^ b_x;
            OP_NOT:     alu_res = {~A1, ~B1};
            default:    alu_res = '0;
        endcase
    end

    always_comb begin
        stg_vld_d = '0;
        for (int i = 0; i < NSTG; i++) begin
            stg_prod_d[i] = '0;
            stg_tag_d[i]  = '0;
        end
        if (MUL_LATENCY > 1) begin
            stg_vld_d[0]  = accept && is_mul;
            stg_prod_d[0] = alu_res;
            stg_tag_d[0]  = tag_in;
            for (int i = 1; i < NSTG; i++) begin
                stg_vld_d[i]  = stg_vld_q[i-1];
                stg_prod_d[i] = stg_prod_q[i-1];
                stg_tag_d[i]  = stg_tag_q[i-1];
            end
        end
    end

    // The handshake guarantees a retiring MUL and a newly accepted non-MUL never meet here.
    always_comb begin
        result_d  = result_q;
        tag_d     = tag_q;
        end_op_d  = 1'b0;
        out_mul_d = 1'b0;
        if ((MUL_LATENCY > 1) && stg_vld_q[NSTG-1]) begin
            result_d  = stg_prod_q[NSTG-1];
            tag_d     = stg_tag_q[NSTG-1];
            end_op_d  = 1'b1;
            out_mul_d = 1'b1;
        end else if (accept && (!is_mul || (MUL_LATENCY <= 1))) begin
            result_d  = alu_res;
            tag_d     = tag_in;
            end_op_d  = 1'b1;
            out_mul_d = is_mul;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld_q <= '0;
            for (int i = 0; i < NSTG; i++) begin
                stg_prod_q[i] <= '0;
                stg_tag_q[i]  <= '0;
            end
            result_q  <= '0;
            tag_q     <= '0;
            end_op_q  <= 1'b0;
            out_mul_q <= 1'b0;
        end else begin
            stg_vld_q <= stg_vld_d;
            for (int i = 0; i < NSTG; i++) begin
                stg_prod_q[i] <= stg_prod_d[i];
                stg_tag_q[i]  <= stg_tag_d[i];
            end
            result_q  <= result_d;
            tag_q     <= tag_d;
            end_op_q  <= end_op_d;
            out_mul_q <= out_mul_d;
        end
    end

    assign result  = result_q;
    assign tag_out = tag_q;
    assign end_op  = end_op_q;
    assign busy    = (|stg_vld_q) || (end_op_q && out_mul_q);

endmodule

// File: tb/tb_pipelined_tiny_alu.sv
// Directed table plus hand sequences and a scoreboarded random run for pipelined_tiny_alu.
module tb_pipelined_tiny_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_op;
    logic [2:0]  op_sel;
    logic [15:0] A1, B1;
    logic [3:0]  tag_in;
    logic        in_ready;
    logic [31:0] result;
    logic [3:0]  tag_out;
    logic        end_op;
    logic        busy;

    pipelined_tiny_alu #(.DATA_WIDTH(16), .MUL_LATENCY(3), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start_op(start_op), .op_sel(op_sel),
        .A1(A1), .B1(B1), .tag_in(tag_in), .in_ready(in_ready),
        .result(result), .tag_out(tag_out), .end_op(end_op), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        int          due;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] ax, bx;
        ax = {16'h0, a};
        bx = {16'h0, b};
        case (op)
            3'd0: return ax * bx;
            3'd1: return ax + bx;
            3'd2: return ax - bx;
            3'd3: return ax + bx + 32'd1;
            3'd4: return ax | bx;
            3'd5: return ax & bx;
            3'd6: return ax ^ bx;
            default: return {~a, ~b};
        endcase
    endfunction

    initial begin
        int k;
        int lat;
        int last_mul_done;
        logic go;
        logic exp_rdy;
        exp_t e;

        vecs[0]  = '{3'd0, 16'd42, 16'd21, 32'd882};
        vecs[1]  = '{3'd1, 16'd42, 16'd21, 32'd63};
        vecs[2]  = '{3'd2, 16'd42, 16'd21, 32'd21};
        vecs[3]  = '{3'd3, 16'd42, 16'd21, 32'd64};
        vecs[4]  = '{3'd4, 16'd42, 16'd21, 32'd63};
        vecs[5]  = '{3'd5, 16'd42, 16'd21, 32'd0};
        vecs[6]  = '{3'd6, 16'd42, 16'd21, 32'd63};
        vecs[7]  = '{3'd7, 16'd42, 16'd21, 32'hFFD5_FFEA};
        vecs[8]  = '{3'd0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[9]  = '{3'd1, 16'hFFFF, 16'hFFFF, 32'h0001_FFFE};
        vecs[10] = '{3'd3, 16'hFFFF, 16'hFFFF, 32'h0001_FFFF};
        vecs[11] = '{3'd7, 16'hFFFF, 16'hFFFF, 32'h0000_0000};
        vecs[12] = '{3'd2, 16'h0000, 16'h0001, 32'hFFFF_FFFF};
        vecs[13] = '{3'd6, 16'hF0F0, 16'h0FF0, 32'h0000_FF00};

        rst = 1'b1; start_op = 1'b0; op_sel = 3'd0; A1 = '0; B1 = '0; tag_in = '0;
        step();
        step();
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_end_op", 64'(end_op), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed table: each op issued alone, latency/result/tag checked.
        for (int i = 0; i < 14; i++) begin
            op_sel = vecs[i].op; A1 = vecs[i].a; B1 = vecs[i].b; tag_in = 4'(i);
            start_op = 1'b1;
            #1;
            chk("vec_in_ready", 64'(in_ready), 64'd1);
            step();
            start_op = 1'b0;
            lat = (vecs[i].op == 3'd0) ? 3 : 1;
            k = 1;
            while (!end_op && k < 8) begin
                step();
                k++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(k), 64'(lat));
            chk($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_tag", i), 64'(tag_out), 64'(i));
            step();
            chk($sformatf("vec%0d_pulse", i), 64'(end_op), 64'd0);
            chk($sformatf("vec%0d_hold", i), 64'(result), 64'(vecs[i].exp));
        end

        // Back-to-back MULs complete on consecutive cycles.
        op_sel = 3'd0; start_op = 1'b1;
        A1 = 16'd2; B1 = 16'd3; tag_in = 4'd0; step();
        chk("b2b_busy", 64'(busy), 64'd1);
        A1 = 16'd4; B1 = 16'd5; tag_in = 4'd1; step();
        A1 = 16'd6; B1 = 16'd7; tag_in = 4'd2; step();
        start_op = 1'b0;
        chk("b2b0_end", 64'(end_op), 64'd1);
        chk("b2b0_res", 64'(result), 64'd6);
        chk("b2b0_tag", 64'(tag_out), 64'd0);
        step();
        chk("b2b1_end", 64'(end_op), 64'd1);
        chk("b2b1_res", 64'(result), 64'd20);
        chk("b2b1_tag", 64'(tag_out), 64'd1);
        step();
        chk("b2b2_end", 64'(end_op), 64'd1);
        chk("b2b2_res", 64'(result), 64'd42);
        chk("b2b2_tag", 64'(tag_out), 64'd2);
        step();
        chk("b2b_idle_end", 64'(end_op), 64'd0);
        chk("b2b_idle_busy", 64'(busy), 64'd0);

        // MUL then ADD: ADD stalls until the MUL's end_op cycle.
        op_sel = 3'd0; A1 = 16'd3; B1 = 16'd4; tag_in = 4'd5; start_op = 1'b1;
        step();
        op_sel = 3'd1; A1 = 16'd1; B1 = 16'd1; tag_in = 4'd6;
        #1;
        chk("stall_rdy_e1", 64'(in_ready), 64'd0);
        chk("stall_busy_e0", 64'(busy), 64'd1);
        step();
        chk("stall_end_e1", 64'(end_op), 64'd0);
        chk("stall_rdy_e2", 64'(in_ready), 64'd0);
        step();
        chk("stall_mul_end", 64'(end_op), 64'd1);
        chk("stall_mul_res", 64'(result), 64'd12);
        chk("stall_mul_tag", 64'(tag_out), 64'd5);
        chk("stall_rdy_e3", 64'(in_ready), 64'd1);
        chk("stall_busy_e2", 64'(busy), 64'd1);
        step();
        start_op = 1'b0;
        chk("stall_add_end", 64'(end_op), 64'd1);
        chk("stall_add_res", 64'(result), 64'd2);
        chk("stall_add_tag", 64'(tag_out), 64'd6);
        chk("stall_busy_e3", 64'(busy), 64'd0);
        step();

        // Reset mid-MUL: the flushed op never reports.
        op_sel = 3'd0; A1 = 16'd9; B1 = 16'd9; tag_in = 4'd9; start_op = 1'b1;
        step();
        start_op = 1'b0;
        rst = 1'b1;
        #1;
        chk("flush_busy", 64'(busy), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("flush_no_end", 64'(end_op), 64'd0);
            step();
        end

        // Random run with scoreboard and occasional reset.
        last_mul_done = -1;
        sb.delete();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(399) == 0) begin
                start_op = 1'b0;
                rst = 1'b1;
                #1;
                chk("rnd_rst_busy", 64'(busy), 64'd0);
                chk("rnd_rst_end", 64'(end_op), 64'd0);
                step();
                rst = 1'b0;
                sb.delete();
                last_mul_done = -1;
                continue;
            end
            go = 1'($urandom_range(1));
            op_sel = 3'($urandom_range(7));
            A1 = 16'($urandom);
            B1 = 16'($urandom);
            tag_in = 4'($urandom);
            start_op = go;
            exp_rdy = (op_sel == 3'd0) || (last_mul_done <= cyc);
            #1;
            chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("rnd_busy", 64'(busy), 64'(cyc <= last_mul_done));
            if (go && exp_rdy) begin
                e.res = alu_ref(op_sel, A1, B1);
                e.tag = tag_in;
                e.due = cyc + ((op_sel == 3'd0) ? 3 : 1);
                sb.push_back(e);
                if (op_sel == 3'd0) last_mul_done = cyc + 3;
            end
            step();
            start_op = 1'b0;
            if (end_op) begin
                if (sb.size() == 0) begin
                    chk("rnd_spurious_end", 64'(end_op), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rnd_res", 64'(result), 64'(e.res));
                    chk("rnd_tag", 64'(tag_out), 64'(e.tag));
                    chk("rnd_due", 64'(cyc), 64'(e.due));
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("rnd_missing_end", 64'(end_op), 64'd1);
            end
        end

        start_op = 1'b0;
        k = 0;
        while (sb.size() != 0 && k < 10) begin
            step();
            k++;
            if (end_op) begin
                e = sb.pop_front();
                chk("drain_res", 64'(result), 64'(e.res));
                chk("drain_tag", 64'(tag_out), 64'(e.tag));
                chk("drain_due", 64'(cyc), 64'(e.due));
            end
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
